// File: rtl/mips_fetch_unit.sv
// Instruction fetch unit: program memory plus PC, one registered instruction per clock to the CPU.
// Latency: one cycle from start/redirect/PC advance to the presented instruction.
// Backpressure: stall holds instruction, pc and instr_valid; redirect overrides stall. Optional counter: FETCH_COUNT_EN.
module mips_fetch_unit #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [31:0]           redirect_pc,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [31:0]           load_data,
    output logic [31:0]           instruction,
    output logic [31:0]           pc,
    output logic                  instr_valid,
    output logic                  halted,
    output logic [31:0]           fetch_count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] mem [0:DEPTH-1];

    logic        do_fetch;
    logic [31:0] fetch_addr;
    logic [31:0] fetch_word;
    logic        is_halt;
    logic        load_ok;

    // Select this edge's fetch address: start restarts at RESET_PC, redirect beats stall in RUN.
    always_comb begin
        do_fetch   = 1'b0;
        fetch_addr = fetch_pc;
        case (state)
            IDLE, HALT: begin
                if (start) begin
                    do_fetch   = 1'b1;
                    fetch_addr = RESET_PC;
                end
            end
            RUN: begin
                if (redirect) begin
                    do_fetch   = 1'b1;
                    fetch_addr = redirect_pc;
                end else if (!stall) begin
                    do_fetch   = 1'b1;
                end
            end
            default: begin
                do_fetch   = 1'b0;
                fetch_addr = fetch_pc;
            end
        endcase
    end

    assign fetch_word = mem[fetch_addr[ADDR_WIDTH+1:2]];
    assign is_halt    = (fetch_word == HALT_WORD);
    // Program writes only while fetch is parked, and never on the same edge as a restart.
    assign load_ok    = load_en && !start && (state != RUN) && !reset;

    // Program memory write port; contents survive reset.
    always_ff @(posedge clock) begin
        if (load_ok) begin
            mem[load_addr] <= load_data;
        end
    end

    // Fetch state machine with registered outputs; a fetched sentinel parks the unit in HALT.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            instruction <= 32'h0;
            pc          <= 32'h0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else if (do_fetch) begin
            pc       <= {fetch_addr[31:2], 2'b00};
            fetch_pc <= fetch_addr + 32'd4;
            if (is_halt) begin
                instruction <= 32'h0;
                instr_valid <= 1'b0;
                halted      <= 1'b1;
                state       <= HALT;
            end else begin
                instruction <= fetch_word;
                instr_valid <= 1'b1;
                halted      <= 1'b0;
                state       <= RUN;
            end
        end
    end

`ifdef FETCH_COUNT_EN
    // Count presented valid instructions; a restart clears the count and includes its own fetch.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_count <= 32'h0;
        end else if (do_fetch) begin
            if (state != RUN) begin
                fetch_count <= is_halt ? 32'h0 : 32'h1;
            end else if (!is_halt) begin
                fetch_count <= fetch_count + 32'h1;
            end
        end
    end
`else
    assign fetch_count = 32'h0;
`endif

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Bench for mips_fetch_unit: directed program runs on a default-size and a 4-word instance.
// Latency: expectations are queued one edge ahead and checked on the following falling edge.
// Backpressure: exercises stall, redirect-with-stall, sentinel halt, index wrap and mid-run reset.
module tb_mips_fetch_unit;

    logic        clock;
    logic        reset;
    logic        stall, redirect;
    logic [31:0] redirect_pc;

    logic        a_start, a_load_en;
    logic [7:0]  a_load_addr;
    logic [31:0] a_load_data;
    logic [31:0] a_instr, a_pc, a_cnt;
    logic        a_valid, a_halted;

    logic        b_start, b_load_en;
    logic [1:0]  b_load_addr;
    logic [31:0] b_load_data;
    logic [31:0] b_instr, b_pc, b_cnt;
    logic        b_valid, b_halted;

    mips_fetch_unit #(.ADDR_WIDTH(8)) dut_a (
        .clock(clock), .reset(reset), .start(a_start), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .load_en(a_load_en),
        .load_addr(a_load_addr), .load_data(a_load_data), .instruction(a_instr),
        .pc(a_pc), .instr_valid(a_valid), .halted(a_halted), .fetch_count(a_cnt)
    );

    mips_fetch_unit #(.ADDR_WIDTH(2)) dut_b (
        .clock(clock), .reset(reset), .start(b_start), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .load_en(b_load_en),
        .load_addr(b_load_addr), .load_data(b_load_data), .instruction(b_instr),
        .pc(b_pc), .instr_valid(b_valid), .halted(b_halted), .fetch_count(b_cnt)
    );

    typedef struct {
        int          due;
        bit          which;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic        halted;
        logic [31:0] cnt;
        int          tag;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    localparam logic [31:0] P0 = 32'h20080006;
    localparam logic [31:0] P1 = 32'h2009000B;
    localparam logic [31:0] P2 = 32'h2108000A;
    localparam logic [31:0] P3 = 32'h212A00F0;
    localparam logic [31:0] PH = 32'hFFFFFFFF;
    localparam logic [31:0] B0 = 32'h24010001;
    localparam logic [31:0] B1 = 32'h24020002;
    localparam logic [31:0] B2 = 32'h24030003;
    localparam logic [31:0] B3 = 32'h24040004;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] ec(input int n);
`ifdef FETCH_COUNT_EN
        return n;
`else
        return 32'h0 + 0 * n;
`endif
    endfunction

    // Queue the outputs expected right after the next rising edge.
    task automatic ex(input bit w, input logic [31:0] i, input logic [31:0] p,
                      input logic v, input logic h, input int n, input int tag);
        exp_t e;
        e.due = cyc + 1; e.which = w; e.instr = i; e.pc = p;
        e.valid = v; e.halted = h; e.cnt = ec(n); e.tag = tag;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: pop every expectation due this cycle and compare against the selected instance.
    always @(negedge clock) begin : monitor
        exp_t        e;
        logic [31:0] gi, gp, gc;
        logic        gv, gh;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            checks = checks + 1;
            if (e.due < cyc) begin
                failures = failures + 1;
                $display("FAIL tag=%0d expectation missed its cycle (due %0d, now %0d)", e.tag, e.due, cyc);
            end else begin
                gi = e.which ? b_instr : a_instr;
                gp = e.which ? b_pc : a_pc;
                gv = e.which ? b_valid : a_valid;
                gh = e.which ? b_halted : a_halted;
                gc = e.which ? b_cnt : a_cnt;
                if (gi !== e.instr || gp !== e.pc || gv !== e.valid || gh !== e.halted || gc !== e.cnt) begin
                    failures = failures + 1;
                    $display("FAIL tag=%0d dut=%0d got instr=%h pc=%h v=%b h=%b cnt=%0d want instr=%h pc=%h v=%b h=%b cnt=%0d",
                             e.tag, e.which, gi, gp, gv, gh, gc, e.instr, e.pc, e.valid, e.halted, e.cnt);
                end
            end
        end
    end

    // Start instance A and expect the whole sentinel-terminated program.
    task automatic run_prog_a(input int tag);
        a_start = 1'b1; ex(0, P0, 32'd0, 1, 0, 1, tag); tick();
        a_start = 1'b0; ex(0, P1, 32'd4, 1, 0, 2, tag + 1); tick();
        ex(0, P2, 32'd8, 1, 0, 3, tag + 2); tick();
        ex(0, P3, 32'd12, 1, 0, 4, tag + 3); tick();
        ex(0, 32'h0, 32'd16, 0, 1, 4, tag + 4); tick();
        ex(0, 32'h0, 32'd16, 0, 1, 4, tag + 5); tick();
    endtask

    initial begin
        logic [31:0] prog [0:4];
        logic [31:0] bprog [0:3];
        prog[0] = P0; prog[1] = P1; prog[2] = P2; prog[3] = P3; prog[4] = PH;
        bprog[0] = B0; bprog[1] = B1; bprog[2] = B2; bprog[3] = B3;
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        a_start = 1'b0; a_load_en = 1'b0; a_load_addr = 8'h0; a_load_data = 32'h0;
        b_start = 1'b0; b_load_en = 1'b0; b_load_addr = 2'h0; b_load_data = 32'h0;
        tick();

        // Reset state on both instances.
        ex(0, 32'h0, 32'h0, 0, 0, 0, 1);
        ex(1, 32'h0, 32'h0, 0, 0, 0, 2);
        tick();
        reset = 1'b0;

        // Load program; outputs hold in IDLE.
        for (int i = 0; i < 5; i++) begin
            a_load_en = 1'b1; a_load_addr = 8'(i); a_load_data = prog[i];
            ex(0, 32'h0, 32'h0, 0, 0, 0, 10 + i);
            tick();
        end
        a_load_en = 1'b0;

        // Straight run to the sentinel.
        run_prog_a(20);

        // Restart, stall three cycles at pc=4; a RUN-time write to mem[3] must be ignored.
        a_start = 1'b1; ex(0, P0, 32'd0, 1, 0, 1, 30); tick();
        a_start = 1'b0; ex(0, P1, 32'd4, 1, 0, 2, 31); tick();
        stall = 1'b1;
        a_load_en = 1'b1; a_load_addr = 8'd3; a_load_data = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            ex(0, P1, 32'd4, 1, 0, 2, 32 + i); tick();
            a_load_en = 1'b0;
        end
        stall = 1'b0;
        ex(0, P2, 32'd8, 1, 0, 3, 35); tick();
        ex(0, P3, 32'd12, 1, 0, 4, 36); tick();
        ex(0, 32'h0, 32'd16, 0, 1, 4, 37); tick();

        // Redirect with stall to 0x0E (low bits dropped); load with start must be ignored.
        a_start = 1'b1; a_load_en = 1'b1; a_load_addr = 8'd2; a_load_data = 32'h11111111;
        ex(0, P0, 32'd0, 1, 0, 1, 40); tick();
        a_start = 1'b0; a_load_en = 1'b0;
        ex(0, P1, 32'd4, 1, 0, 2, 41); tick();
        redirect = 1'b1; redirect_pc = 32'h0000000E; stall = 1'b1;
        ex(0, P3, 32'd12, 1, 0, 3, 42); tick();
        redirect = 1'b0; stall = 1'b0;
        ex(0, 32'h0, 32'd16, 0, 1, 3, 43); tick();

        // Four-word instance: index wrap and RUN-time load ignored.
        for (int i = 0; i < 4; i++) begin
            b_load_en = 1'b1; b_load_addr = 2'(i); b_load_data = bprog[i];
            tick();
        end
        b_load_en = 1'b0;
        b_start = 1'b1; ex(1, B0, 32'd0, 1, 0, 1, 50); tick();
        b_start = 1'b0;
        b_load_en = 1'b1; b_load_addr = 2'd1; b_load_data = PH;
        ex(1, B1, 32'd4, 1, 0, 2, 51); tick();
        b_load_en = 1'b0;
        ex(1, B2, 32'd8, 1, 0, 3, 52); tick();
        ex(1, B3, 32'd12, 1, 0, 4, 53); tick();
        ex(1, B0, 32'd16, 1, 0, 5, 54); tick();
        ex(1, B1, 32'd20, 1, 0, 6, 55); tick();

        // Mid-run reset on both, then restart A with memory intact.
        a_start = 1'b1; tick();
        a_start = 1'b0; reset = 1'b1;
        ex(0, 32'h0, 32'h0, 0, 0, 0, 60);
        ex(1, 32'h0, 32'h0, 0, 0, 0, 61);
        tick();
        reset = 1'b0;
        ex(0, 32'h0, 32'h0, 0, 0, 0, 62);
        ex(1, 32'h0, 32'h0, 0, 0, 0, 63);
        tick();
        run_prog_a(70);

        tick(); tick();
        if (q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL queue_drain left=%0d want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
